// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: FCR decode, RX trigger/stop flags and character-timeout sequencer for the 16750 FIFO pair
module uart_fifo_ctrl #(
  parameter int SIZE_E     = 6,
  parameter int TOUT_CHARS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FCR_WE,
  input  logic [7:0]        FCR_D,
  input  logic              DLAB,
  input  logic [SIZE_E-1:0] RX_USAGE,
  input  logic              RX_EMPTY,
  input  logic              RX_FULL,
  input  logic              RX_WRITE,
  input  logic              RX_READ,
  input  logic              CHAR_TICK,
  output logic              FIFO_EN,
  output logic              FIFO64,
  output logic              RX_CLEAR,
  output logic              TX_CLEAR,
  output logic              RX_TRIG,
  output logic              RX_STOP,
  output logic              RX_TIMEOUT
);
  typedef enum logic [1:0] {IDLE, COUNT, TOUT} state_t;
  localparam logic [2:0] TC = 3'(TOUT_CHARS);
  state_t state;
  logic [2:0] cnt;
  logic [1:0] trig_sel;
  logic [SIZE_E:0] fill, thresh;
  logic act;
  // fill widened by one bit so a full FIFO (usage wrapped to 0) still reads as its depth
  always_comb begin
    fill = RX_FULL ? {1'b1, {SIZE_E{1'b0}}} : {1'b0, RX_USAGE};
    thresh = FIFO64 ? (trig_sel[1] ? (trig_sel[0] ? (SIZE_E+1)'(56) : (SIZE_E+1)'(32))
                                   : (trig_sel[0] ? (SIZE_E+1)'(16) : (SIZE_E+1)'(1)))
                    : (trig_sel[1] ? (trig_sel[0] ? (SIZE_E+1)'(14) : (SIZE_E+1)'(8))
                                   : (trig_sel[0] ? (SIZE_E+1)'(4)  : (SIZE_E+1)'(1)));
    act = RX_WRITE | RX_READ;
  end
  // FCR latch; toggling the enable clears both FIFOs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FIFO_EN  <= 1'b0;
      FIFO64   <= 1'b0;
      trig_sel <= 2'b00;
      RX_CLEAR <= 1'b0;
      TX_CLEAR <= 1'b0;
    end else begin
      RX_CLEAR <= FCR_WE & (FCR_D[1] | (FCR_D[0] != FIFO_EN));
      TX_CLEAR <= FCR_WE & (FCR_D[2] | (FCR_D[0] != FIFO_EN));
      if (FCR_WE) begin
        FIFO_EN  <= FCR_D[0];
        trig_sel <= FCR_D[7:6];
        if (DLAB) FIFO64 <= FCR_D[5];
      end
    end
  end
  // fill-level flags; trigger suppressed the cycle after an RX clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RX_TRIG <= 1'b0;
      RX_STOP <= 1'b0;
    end else begin
      RX_TRIG <= RX_CLEAR ? 1'b0 : FIFO_EN ? (fill >= thresh) : !RX_EMPTY;
      RX_STOP <= FIFO_EN ? (FIFO64 ? RX_FULL : (fill >= (SIZE_E+1)'(16))) : !RX_EMPTY;
    end
  end
  // character-timeout sequencer; RX activity restarts the count and wins over a same-cycle tick
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      RX_TIMEOUT <= 1'b0;
    end else if (!FIFO_EN || RX_CLEAR) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      RX_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt        <= 3'd0;
          RX_TIMEOUT <= 1'b0;
          if (!RX_EMPTY) state <= COUNT;
        end
        COUNT: begin
          if (RX_EMPTY) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (act) begin
            cnt <= 3'd0;
          end else if (CHAR_TICK) begin
            cnt <= (cnt >= TC) ? TC : cnt + 3'd1;
            if (cnt + 3'd1 >= TC) begin
              state      <= TOUT;
              RX_TIMEOUT <= 1'b1;
            end
          end
        end
        TOUT: begin
          if (RX_EMPTY) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            RX_TIMEOUT <= 1'b0;
          end else if (act) begin
            state      <= COUNT;
            cnt        <= 3'd0;
            RX_TIMEOUT <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 3'd0;
          RX_TIMEOUT <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: randomized scoreboard bench for uart_fifo_ctrl against an occupancy-level model
module tb_uart_fifo_ctrl;
  logic CLK = 0, RST = 0, FCR_WE = 0, DLAB = 0, RX_EMPTY = 1, RX_FULL = 0;
  logic RX_WRITE = 0, RX_READ = 0, CHAR_TICK = 0;
  logic [7:0] FCR_D = 0;
  logic [5:0] RX_USAGE = 0;
  logic FIFO_EN, FIFO64, RX_CLEAR, TX_CLEAR, RX_TRIG, RX_STOP, RX_TIMEOUT;

  uart_fifo_ctrl #(.SIZE_E(6), .TOUT_CHARS(4)) dut (
    .CLK(CLK), .RST(RST), .FCR_WE(FCR_WE), .FCR_D(FCR_D), .DLAB(DLAB),
    .RX_USAGE(RX_USAGE), .RX_EMPTY(RX_EMPTY), .RX_FULL(RX_FULL),
    .RX_WRITE(RX_WRITE), .RX_READ(RX_READ), .CHAR_TICK(CHAR_TICK),
    .FIFO_EN(FIFO_EN), .FIFO64(FIFO64), .RX_CLEAR(RX_CLEAR), .TX_CLEAR(TX_CLEAR),
    .RX_TRIG(RX_TRIG), .RX_STOP(RX_STOP), .RX_TIMEOUT(RX_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_e, mon_a;
  string names[7] = '{"fifo_en", "fifo64", "rx_clear", "tx_clear", "rx_trig", "rx_stop", "rx_timeout"};
  int thr_lo[4] = '{1, 4, 8, 14};
  int thr_hi[4] = '{1, 16, 32, 56};
  int picks[14] = '{0, 1, 7, 8, 13, 14, 15, 16, 31, 32, 55, 56, 63, 64};

  int occ = 0;
  bit m_en, m64, m_rc, m_tc, m_tr, m_st, m_to, m_arm;
  bit [1:0] m_sel;
  int m_q;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {FIFO_EN, FIFO64, RX_CLEAR, TX_CLEAR, RX_TRIG, RX_STOP, RX_TIMEOUT};
  endfunction

  task automatic model_reset();
    {m_en, m64, m_rc, m_tc, m_tr, m_st, m_to, m_arm} = '0;
    m_sel = 0;
    m_q = 0;
    occ = 0;
  endtask

  // one clock of stimulus; the expected post-edge outputs go to the scoreboard queue
  task automatic cycle(input bit we, input bit [7:0] d, input bit dlab, input bit w, input bit r, input bit tick);
    int thr, n_q;
    bit n_tr, n_st, n_to, n_rc, n_tc, n_arm, pw, pr;
    @(negedge CLK);
    pw = w && occ < 64;
    pr = r && occ > 0;
    RX_USAGE = 6'(occ % 64);
    RX_FULL = occ == 64;
    RX_EMPTY = occ == 0;
    RX_WRITE = pw;
    RX_READ = pr;
    CHAR_TICK = tick;
    FCR_WE = we;
    FCR_D = d;
    DLAB = dlab;
    thr = m64 ? thr_hi[m_sel] : thr_lo[m_sel];
    n_tr = m_rc ? 1'b0 : m_en ? (occ >= thr) : (occ != 0);
    n_st = m_en ? (m64 ? occ == 64 : occ >= 16) : (occ != 0);
    if (!m_en || m_rc || occ == 0) begin
      n_arm = 0;
      n_q = 0;
    end else if (!m_arm) begin
      n_arm = 1;
      n_q = 0;
    end else begin
      n_arm = 1;
      n_q = (pw || pr) ? 0 : m_q + int'(tick);
    end
    n_to = n_arm && n_q >= 4;
    n_rc = we && (d[1] || d[0] != m_en);
    n_tc = we && (d[2] || d[0] != m_en);
    occ = m_rc ? 0 : occ + int'(pw) - int'(pr);
    if (we) begin
      m_en = d[0];
      m_sel = d[7:6];
      if (dlab) m64 = d[5];
    end
    {m_rc, m_tc, m_tr, m_st, m_to, m_arm, m_q} = {n_rc, n_tc, n_tr, n_st, n_to, n_arm, n_q};
    exp_q.push_back({m_en, m64, m_rc, m_tc, m_tr, m_st, m_to});
  endtask

  // monitor: compares every presented cycle against the oldest queued expectation
  initial forever begin
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = outs();
      for (int i = 0; i < 7; i++) chk(names[i], mon_a[6-i], mon_e[6-i]);
    end
  end

  initial begin
    int act_div;
    bit [7:0] d;
    model_reset();
    #1 RST = 1;
    #1;
    mon_a = outs();
    for (int i = 0; i < 7; i++) chk({"reset_", names[i]}, mon_a[6-i], 1'b0);
    @(negedge CLK);
    RST = 0;
    cycle(1, 8'h07, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    cycle(1, 8'h01, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    for (int p = 0; p < 24; p++) begin
      d = 8'($urandom);
      d[0] = (p % 6) != 5;
      cycle(1, d, p[0], 0, 0, 0);
      act_div = (p % 3 == 0) ? 40 : 4;
      for (int c = 0; c < 120; c++) begin
        if ($urandom % 20 == 0) occ = picks[$urandom % 14];
        if ($urandom % 80 == 0)
          cycle(1, 8'($urandom), 1'($urandom), 0, 0, 1'($urandom));
        else
          cycle(0, 8'h00, 0, $urandom % act_div == 0, $urandom % (act_div + 1) == 0, $urandom % 2 == 0);
      end
    end
    cycle(1, 8'h07, 0, 0, 0, 0);
    cycle(1, 8'h06, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1;
    #1;
    mon_a = outs();
    for (int i = 0; i < 7; i++) chk({"midreset_", names[i]}, mon_a[6-i], 1'b0);
    model_reset();
    @(negedge CLK);
    RST = 0;
    cycle(1, 8'h01, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    repeat (5) @(posedge CLK);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
